rr_grant_sequencer_16: RTL and testbench
========================================

Name: rr_grant_sequencer_16

Overview:
- 16-requester round-robin arbiter that sequences the shared one-hot select line of the 4-to-16 decode path.
- Owns a single resource: at most one requester is selected at any time.
- Emits the winner both as an index and as the 4-bit select code consumed by the team's 4-to-16 decoder.
- Sits between bus masters and the decoder. Enforces a bounded hold time and one turnaround cycle between grants.

Parameters:
- MAX_HOLD, 8, maximum consecutive cycles one grant may be held before forced release (legal range 1..255).
- HOLD_W, 8, width of the hold counter (must satisfy 2**HOLD_W > MAX_HOLD).

Ports:
- clk  input  1  sole clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- req  input  16  request vector, bit i = requester i; level-sensitive.
- gnt_valid  output  1  a grant is active this cycle.
- gnt_idx  output  4  index of the granted requester (0..15).
- gnt_code  output  4  decoder select code, always 15 - gnt_idx; decoder line Y[i] is then requester i.
- gnt_onehot  output  16  one-hot grant; bit gnt_idx set when gnt_valid is 1, all zero otherwise.
- forced_rel  output  1  one-cycle pulse: the current grant was revoked by hold-limit expiry.

Behaviour:
- Reset (async assert, sync deassert handled upstream) drives these values immediately:
  - gnt_valid=0, gnt_idx=0, gnt_code=4'hF, gnt_onehot=0, forced_rel=0.
  - Internal: ptr=0, hold_cnt=0, state=IDLE.
- All outputs are registered. No combinational path from req to any output.
- States:
  - IDLE: gnt_valid=0. If any req bit is set, pick winner w = first set bit at or after ptr, wrapping 15->0. Next cycle: state=GRANT, gnt_idx=w, hold_cnt=0. If req==0, stay in IDLE.
  - GRANT: gnt_valid=1.
    - If req[gnt_idx]==0 at the edge: go to IDLE, ptr=gnt_idx+1 (mod 16).
    - Else if hold_cnt==MAX_HOLD-1: go to IDLE, ptr=gnt_idx+1, forced_rel=1 for the first IDLE cycle.
    - Else: hold_cnt+1, grant unchanged.
- Latency: req set while in IDLE gives gnt_valid high on the next rising edge (1 cycle).
- Turnaround: at least one IDLE cycle (gnt_valid=0) between any two grants, including grants to the same requester.
- Grant length:
  - A requester holding req continuously receives exactly MAX_HOLD cycles of gnt_valid.
  - It is then released, and other requesters are searched first.
- Fairness: after requester k is served, the search starts at k+1. Any continuously asserted request is granted within 15 grant periods.
- Requests for bits other than gnt_idx that change during GRANT have no effect until the next IDLE.
- gnt_idx and gnt_code hold their last value while in IDLE. Only gnt_valid and gnt_onehot clear.
- MAX_HOLD=1: each grant lasts exactly 1 cycle. forced_rel pulses after every grant whose req is still high.
- Reset mid-grant: outputs clear immediately, the pointer returns to 0, and no forced_rel is produced.
- hold_cnt never wraps; it saturates at MAX_HOLD-1 by construction.

Decomposition:
- Shared package rr_grant_pkg holds:
  - constants NUM_REQ=16, IDX_W=4;
  - state enum {IDLE, GRANT};
  - function code_of(idx) = 15 - idx.
- One natural sub-module: rr_pick16. Purely combinational; inputs req[15:0] and ptr[3:0]; outputs any and win[3:0]. Implement it as a rotate, priority encode, then un-rotate.
- The arbiter FSM, pointer and hold counter stay in the top module.

Test Plan:
- Reset: assert rst mid-grant with req=16'hFFFF -> gnt_valid=0, gnt_onehot=0, gnt_code=4'hF in the same cycle. After release, the first grant is idx 0.
- Single requester: req=16'h0020, dropped after 3 cycles of gnt_valid -> gnt_idx=5, gnt_code=10, gnt_onehot=16'h0020 for 3 cycles, then gnt_valid=0 and ptr=6.
- Rotation: req=16'h8001 held high, with MAX_HOLD=8 -> grants alternate idx 0, 15, 0, ... Each grant is 8 cycles, separated by one idle cycle with forced_rel=1.
- Wrap-around: ptr=15 (after serving idx 14), req=16'h0006 -> next grant idx 1, then idx 2.
- Hold limit with MAX_HOLD=1: req=16'h0100 constant -> gnt_valid pattern 1,0,1,0; forced_rel pulses in every 0 cycle; gnt_idx stays 8.
- Late arrival: during a grant to idx 3, raise req[2] -> idx 2 is not granted until idx 3 releases. Then with ptr=4 and req=16'h0004 only, idx 2 is granted after one idle cycle.

Source files
------------

// File: rtl/rr_grant_sequencer_16_pkg.sv
// rr_grant_pkg: shared constants, state encoding and select-code helper
// for the 16-requester round-robin grant sequencer.
//   NUM_REQ  number of requesters
//   IDX_W    width of a requester index / decoder select code
//   state_t  arbiter FSM states
//   code_of  requester index -> 4-to-16 decoder select code
package rr_grant_pkg;

    localparam int NUM_REQ = 16;
    localparam int IDX_W   = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    // The decoder's Y outputs run opposite to requester numbering, so the
    // select code is the bitwise complement of the index (15 - idx).
    function automatic logic [IDX_W-1:0] code_of(input logic [IDX_W-1:0] idx);
        return IDX_W'(NUM_REQ - 1) - idx;
    endfunction

endpackage

// File: rtl/rr_grant_sequencer_16_if.sv
// rr_grant_sequencer_16_if: request/grant bundle between the bus masters
// and the grant sequencer.
//   req         request vector, bit i = requester i
//   gnt_valid   a grant is active this cycle
//   gnt_idx     index of the granted requester
//   gnt_code    decoder select code (15 - gnt_idx)
//   gnt_onehot  one-hot grant, zero when no grant is active
//   forced_rel  one-cycle pulse when a grant was revoked by hold-limit expiry
// Modports: master = requester side, slave = arbiter side.
interface rr_grant_sequencer_16_if;
    import rr_grant_pkg::*;

    logic [NUM_REQ-1:0] req;
    logic               gnt_valid;
    logic [IDX_W-1:0]   gnt_idx;
    logic [IDX_W-1:0]   gnt_code;
    logic [NUM_REQ-1:0] gnt_onehot;
    logic               forced_rel;

    modport master (
        output req,
        input  gnt_valid, gnt_idx, gnt_code, gnt_onehot, forced_rel
    );

    modport slave (
        input  req,
        output gnt_valid, gnt_idx, gnt_code, gnt_onehot, forced_rel
    );

endinterface

// File: rtl/rr_grant_sequencer_16_pick.sv
// rr_pick16: combinational round-robin winner search.
//   req  request vector
//   ptr  search start index
//   any  at least one request is set
//   win  first set request at or after ptr, wrapping 15 -> 0
// Rotate so that ptr lands on bit 0, priority-encode the lowest set bit,
// then add ptr back (mod 16) to undo the rotation.
module rr_pick16
    import rr_grant_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic               any,
    output logic [IDX_W-1:0]   win
);

    logic [NUM_REQ-1:0] rot;
    logic [IDX_W-1:0]   off;

    always_comb begin
        // Lower half of the doubled vector shifted right is a rotate right.
        rot = NUM_REQ'({req, req} >> ptr);
        off = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (rot[i]) begin
                off = IDX_W'(i);
            end
        end
        any = |req;
        win = off + ptr;
    end

endmodule

// File: rtl/rr_grant_sequencer_16.sv
// rr_grant_sequencer_16: 16-requester round-robin arbiter driving the
// select line of the 4-to-16 decode path, with bounded hold time and a
// mandatory idle turnaround cycle between grants.
//   clk   rising-edge clock
//   rst   asynchronous active-high reset
//   bus   slave side of rr_grant_sequencer_16_if (req in, grant outputs out)
// Parameters:
//   MAX_HOLD  maximum consecutive grant cycles (1..255)
//   HOLD_W    hold counter width, 2**HOLD_W > MAX_HOLD
//
// state | meaning
// IDLE  | no grant; search from ptr for the next winner
// GRANT | gnt_idx owns the resource; count hold cycles
module rr_grant_sequencer_16
    import rr_grant_pkg::*;
#(
    parameter int MAX_HOLD = 8,
    parameter int HOLD_W   = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    rr_grant_sequencer_16_if.slave   bus
);

    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

    state_t            state;
    logic [IDX_W-1:0]  ptr;
    logic [HOLD_W-1:0] hold_cnt;
    logic              any;
    logic [IDX_W-1:0]  win;

    rr_pick16 u_pick (
        .req (bus.req),
        .ptr (ptr),
        .any (any),
        .win (win)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            ptr            <= '0;
            hold_cnt       <= '0;
            bus.gnt_valid  <= 1'b0;
            bus.gnt_idx    <= '0;
            bus.gnt_code   <= code_of('0);
            bus.gnt_onehot <= '0;
            bus.forced_rel <= 1'b0;
        end else begin
            // forced_rel is only ever raised on the GRANT -> IDLE edge.
            bus.forced_rel <= 1'b0;
            case (state)
                IDLE: begin
                    if (any) begin
                        state          <= GRANT;
                        hold_cnt       <= '0;
                        bus.gnt_valid  <= 1'b1;
                        bus.gnt_idx    <= win;
                        bus.gnt_code   <= code_of(win);
                        bus.gnt_onehot <= NUM_REQ'(1) << win;
                    end
                end
                GRANT: begin
                    if (!bus.req[bus.gnt_idx] || hold_cnt == HOLD_LAST) begin
                        // gnt_idx/gnt_code are left holding the last winner.
                        state          <= IDLE;
                        ptr            <= bus.gnt_idx + IDX_W'(1);
                        bus.gnt_valid  <= 1'b0;
                        bus.gnt_onehot <= '0;
                        bus.forced_rel <= bus.req[bus.gnt_idx];
                    end else begin
                        hold_cnt <= hold_cnt + HOLD_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rr_grant_sequencer_16.sv
module tb_rr_grant_sequencer_16;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    rr_grant_sequencer_16_if bus8 ();
    rr_grant_sequencer_16_if bus1 ();

    rr_grant_sequencer_16 #(.MAX_HOLD(8), .HOLD_W(8)) dut8 (
        .clk (clk),
        .rst (rst),
        .bus (bus8.slave)
    );

    rr_grant_sequencer_16 #(.MAX_HOLD(1), .HOLD_W(8)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1.slave)
    );

    typedef struct packed {
        logic [15:0] req;
        logic        valid;
        logic [3:0]  idx;
        logic        forced;
    } vec_t;

    typedef struct {
        int          sel;
        logic        valid;
        logic [3:0]  idx;
        logic        forced;
        string       tag;
    } exp_t;

    exp_t sb[$];
    vec_t tbl[19];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(string name, logic [15:0] act, logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_outputs(int sel, string tag, logic v, logic [3:0] i, logic f);
        logic        av;
        logic [3:0]  ai;
        logic [3:0]  ac;
        logic [15:0] ao;
        logic        af;
        logic [3:0]  ec;
        logic [15:0] eo;
        if (sel == 8) begin
            av = bus8.gnt_valid; ai = bus8.gnt_idx; ac = bus8.gnt_code;
            ao = bus8.gnt_onehot; af = bus8.forced_rel;
        end else begin
            av = bus1.gnt_valid; ai = bus1.gnt_idx; ac = bus1.gnt_code;
            ao = bus1.gnt_onehot; af = bus1.forced_rel;
        end
        ec = 4'hF - i;
        eo = v ? (16'h0001 << i) : 16'h0000;
        chk({tag, " gnt_valid"},  16'(av), 16'(v));
        chk({tag, " gnt_idx"},    16'(ai), 16'(i));
        chk({tag, " gnt_code"},   16'(ac), 16'(ec));
        chk({tag, " gnt_onehot"}, ao,      eo);
        chk({tag, " forced_rel"}, 16'(af), 16'(f));
    endtask

    // Entered in the negedge phase: drive req, queue the expectation,
    // compare just after the next rising edge, return at the next negedge.
    task automatic step(int sel, logic [15:0] r, logic v, logic [3:0] i, logic f, string tag);
        exp_t e;
        if (sel == 8) bus8.req = r;
        else          bus1.req = r;
        e.sel = sel; e.valid = v; e.idx = i; e.forced = f; e.tag = tag;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check_outputs(e.sel, e.tag, e.valid, e.idx, e.forced);
        @(negedge clk);
    endtask

    initial begin
        // single requester 5, dropped after 3 grant cycles -> ptr 6
        tbl[0]  = '{16'h0020, 1'b1, 4'd5,  1'b0};
        tbl[1]  = '{16'h0020, 1'b1, 4'd5,  1'b0};
        tbl[2]  = '{16'h0020, 1'b1, 4'd5,  1'b0};
        tbl[3]  = '{16'h0000, 1'b0, 4'd5,  1'b0};
        // ptr 6 picks 6 over 0
        tbl[4]  = '{16'h0041, 1'b1, 4'd6,  1'b0};
        tbl[5]  = '{16'h0000, 1'b0, 4'd6,  1'b0};
        // serve 14 -> ptr 15, then wrap to 1, then 2
        tbl[6]  = '{16'h4000, 1'b1, 4'd14, 1'b0};
        tbl[7]  = '{16'h0000, 1'b0, 4'd14, 1'b0};
        tbl[8]  = '{16'h0006, 1'b1, 4'd1,  1'b0};
        tbl[9]  = '{16'h0006, 1'b1, 4'd1,  1'b0};
        tbl[10] = '{16'h0004, 1'b0, 4'd1,  1'b0};
        tbl[11] = '{16'h0004, 1'b1, 4'd2,  1'b0};
        tbl[12] = '{16'h0000, 1'b0, 4'd2,  1'b0};
        // late arrival of req[2] during grant to 3
        tbl[13] = '{16'h0008, 1'b1, 4'd3,  1'b0};
        tbl[14] = '{16'h000C, 1'b1, 4'd3,  1'b0};
        tbl[15] = '{16'h000C, 1'b1, 4'd3,  1'b0};
        tbl[16] = '{16'h0004, 1'b0, 4'd3,  1'b0};
        tbl[17] = '{16'h0004, 1'b1, 4'd2,  1'b0};
        tbl[18] = '{16'h0000, 1'b0, 4'd2,  1'b0};

        bus8.req = '0;
        bus1.req = '0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check_outputs(8, "reset8", 1'b0, 4'd0, 1'b0);
        check_outputs(1, "reset1", 1'b0, 4'd0, 1'b0);
        rst = 1'b0;

        for (int k = 0; k < 19; k++) begin
            step(8, tbl[k].req, tbl[k].valid, tbl[k].idx, tbl[k].forced, $sformatf("vec%0d", k));
        end

        // reset in the middle of a grant to 3
        step(8, 16'hFFFF, 1'b1, 4'd3, 1'b0, "rst_pre0");
        step(8, 16'hFFFF, 1'b1, 4'd3, 1'b0, "rst_pre1");
        #2 rst = 1'b1;
        #1 check_outputs(8, "rst_mid", 1'b0, 4'd0, 1'b0);
        @(negedge clk);
        check_outputs(8, "rst_hold", 1'b0, 4'd0, 1'b0);
        rst = 1'b0;

        // rotation 0,15,0,15 with full-length grants and forced releases
        for (int g = 0; g < 4; g++) begin
            for (int c = 0; c < 8; c++) begin
                step(8, 16'h8001, 1'b1, (g % 2 == 1) ? 4'd15 : 4'd0, 1'b0, $sformatf("rot%0d_c%0d", g, c));
            end
            step(8, 16'h8001, 1'b0, (g % 2 == 1) ? 4'd15 : 4'd0, 1'b1, $sformatf("rot%0d_rel", g));
        end
        step(8, 16'h0000, 1'b0, 4'd15, 1'b0, "rot_end");

        // MAX_HOLD = 1
        step(1, 16'h0100, 1'b1, 4'd8, 1'b0, "mh1_g0");
        step(1, 16'h0100, 1'b0, 4'd8, 1'b1, "mh1_r0");
        step(1, 16'h0100, 1'b1, 4'd8, 1'b0, "mh1_g1");
        step(1, 16'h0100, 1'b0, 4'd8, 1'b1, "mh1_r1");
        step(1, 16'h0100, 1'b1, 4'd8, 1'b0, "mh1_g2");
        step(1, 16'h0000, 1'b0, 4'd8, 1'b0, "mh1_drop");

        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard: got %0d entries left expected 0", sb.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
